wake_timer: RTL and testbench
=============================

WAKE_TIMER -- requirements
Module: wake_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, bus clock frequency; sets the 1 s tick period.
REQ-002 Parameter DATA_W, default 32, Wishbone data width; all registers are DATA_W wide.
REQ-003 Port clk_i  input  1  bus clock; the block uses one clock only, all logic on its rising edge.
REQ-004 Port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 Port bus  wishboneSlave.slave  (modport)  Wishbone slave; uses adr_i[3:2], dat_i, dat_o, sel_i, we_i, stb_i, cyc_i, ack_o, err_o, rty_o, tgd_o.
REQ-006 Port irq_o  output  1  alarm interrupt, level-high.

Function
REQ-007 Register map (word index adr_i[3:2]): 0 CTRL (bit0 run, bit1 alarm_en, rest read 0); 1 TIME (seconds of day, 0..86399); 2 ALARM (0..86399); 3 STATUS (bit0 fired, bit1 tick_seen; both W1C).
REQ-008 Bus FSM states IDLE and RESP; IDLE->RESP when cyc_i & stb_i sampled high; RESP->IDLE unconditionally next cycle.
REQ-009 In RESP, exactly one of ack_o or err_o is high for exactly one cycle; a request therefore takes 2 cycles, back-to-back requests 2 cycles each.
REQ-010 dat_o holds the addressed register value, sampled in the IDLE cycle, during the response cycle; dat_o = 0 otherwise.
REQ-011 Writes honour sel_i per byte lane; unselected bytes keep their value.
REQ-012 err_o instead of ack_o when a write to TIME or ALARM would produce a value >= 86400; the register is then left unchanged.
REQ-013 rty_o and tgd_o are tied to 0.
REQ-014 Prescaler counts 0..CLK_HZ-1 while CTRL.run=1; tick is a one-cycle pulse on the cycle the count equals CLK_HZ-1, after which the count returns to 0.
REQ-015 CTRL.run=0 holds the prescaler at 0 and suppresses ticks.
REQ-016 On tick, TIME increments by 1; 86399 wraps to 0; STATUS.tick_seen sets.
REQ-017 STATUS.fired sets when a tick updates TIME to a value equal to ALARM and CTRL.alarm_en=1; bus writes to TIME or ALARM never set fired.
REQ-018 irq_o = STATUS.fired & CTRL.alarm_en, combinational from registers.
REQ-019 Write to TIME in the same cycle as a tick: the written value wins, no increment, the prescaler restarts at 0, and no fire is evaluated that cycle.
REQ-020 A W1C clear in the same cycle as a set of the same STATUS bit: the set wins.
REQ-021 Register writes take effect on the clock edge that enters RESP, so they are visible to a read issued immediately after.

Reset
REQ-022 While rst_n_i=0, asynchronously: FSM=IDLE, ack_o=0, err_o=0, dat_o=0, irq_o=0, CTRL=0, TIME=0, ALARM=0, STATUS=0, prescaler=0.
REQ-023 Reset asserted mid-transaction aborts it with no ack_o and no err_o; the first request after release is served normally.

Structure
REQ-024 Package wake_timer_pkg holds the register index constants, the CTRL/STATUS bit positions, SECONDS_PER_DAY=86400, and the FSM state enum.
REQ-025 Sub-module tick_gen (parameter CLK_HZ; ports clk_i, rst_n_i, run_i, restart_i, tick_o) implements the prescaler.

Verification (CLK_HZ=4)
REQ-026 After reset, read each of the 4 registers -> all return 0, one ack_o per read, err_o=0.
REQ-027 Write TIME=86398, CTRL=1; wait 8 cycles -> TIME reads 0 (wrapped) and STATUS.tick_seen=1.
REQ-028 ALARM=10, TIME=9, CTRL=3; after 4 cycles -> fired=1 and irq_o=1; write STATUS=1 -> irq_o=0.
REQ-029 Write ALARM=86400 -> err_o pulses, ack_o=0, ALARM unchanged; write TIME=0x00000105 with sel_i=0001 onto TIME=0x200 -> TIME=0x205.
REQ-030 Write TIME=50 on the tick cycle -> TIME=50, next tick 4 cycles later; W1C on the fire cycle -> fired stays 1.
REQ-031 Assert rst_n_i while in RESP -> ack_o=0 immediately; after release, a read of CTRL acks and returns 0.

Source files
------------

// File: rtl/wake_timer_pkg.sv
// Shared constants for the wake timer: register indices, bit positions,
// day length and the bus handshake state type.
package wake_timer_pkg;

  // Word indices decoded from adr_i[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TIME   = 2'd1;
  localparam logic [1:0] REG_ALARM  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_RUN_BIT      = 0;
  localparam int CTRL_ALARM_EN_BIT = 1;

  // STATUS bit positions (both write-one-to-clear)
  localparam int STATUS_FIRED_BIT     = 0;
  localparam int STATUS_TICK_SEEN_BIT = 1;

  // Seconds of day run 0 .. SECONDS_PER_DAY-1
  localparam int unsigned SECONDS_PER_DAY = 86400;

  // Bus handshake states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/wishbone_slave_if.sv
// Minimal Wishbone classic bundle used by the wake timer.
interface wishboneSlave #(
  parameter int DATA_W = 32
);
  logic [31:0]         adr_i;
  logic [DATA_W-1:0]   dat_i;
  logic [DATA_W-1:0]   dat_o;
  logic [DATA_W/8-1:0] sel_i;
  logic                we_i;
  logic                stb_i;
  logic                cyc_i;
  logic                ack_o;
  logic                err_o;
  logic                rty_o;
  logic                tgd_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o, rty_o, tgd_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o, rty_o, tgd_o
  );
endinterface

// File: rtl/wake_timer_tick_gen.sv
// One-second prescaler: pulses tick_o for one cycle every CLK_HZ cycles
// while run_i is high. restart_i realigns the second boundary to now.
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic restart_i,
  output logic tick_o
);
  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_count;

  // Tick fires on the last count of each second, only while running
  assign tick_o = run_i & (r_count == CNT_MAX);

  // Count cycles within the current second; hold at 0 when stopped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (!run_i || restart_i || tick_o) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/wake_timer.sv
// Time-of-day counter with alarm, exposed as four Wishbone registers.
// Every request is answered in the following cycle with ack or err.
module wake_timer
  import wake_timer_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int DATA_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  wishboneSlave.slave bus,
  output logic        irq_o
);
  localparam int NB = DATA_W / 8;
  localparam logic [DATA_W-1:0] DAY_C  = DATA_W'(SECONDS_PER_DAY);
  localparam logic [DATA_W-1:0] LAST_C = DATA_W'(SECONDS_PER_DAY - 1);

  bus_state_e        r_state;
  bus_state_e        w_state_next;
  logic              r_run;
  logic              r_alarm_en;
  logic              r_fired;
  logic              r_tick_seen;
  logic [DATA_W-1:0] r_time;
  logic [DATA_W-1:0] r_alarm;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]        w_idx;
  logic              w_req;
  logic              w_wr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_merged;
  logic              w_bad;
  logic              w_ctrl_wr;
  logic              w_time_wr;
  logic              w_alarm_wr;
  logic              w_status_wr;
  logic              w_tick;
  logic              w_tick_eff;
  logic [DATA_W-1:0] w_time_inc;
  logic              w_fire;
  logic              w_clr_fired;
  logic              w_clr_seen;
  logic [31:0]       w_unused_adr;

  assign w_idx        = bus.adr_i[3:2];
  assign w_unused_adr = bus.adr_i;
  assign w_req        = (r_state == ST_IDLE) & bus.cyc_i & bus.stb_i;
  assign w_wr         = w_req & bus.we_i;

  // Addressed register value as seen in the request cycle
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL: begin
        w_rdata[CTRL_RUN_BIT]      = r_run;
        w_rdata[CTRL_ALARM_EN_BIT] = r_alarm_en;
      end
      REG_TIME:  w_rdata = r_time;
      REG_ALARM: w_rdata = r_alarm;
      default: begin
        w_rdata[STATUS_FIRED_BIT]     = r_fired;
        w_rdata[STATUS_TICK_SEEN_BIT] = r_tick_seen;
      end
    endcase
  end

  // Byte-lane merge: unselected lanes keep the current register contents
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = bus.sel_i[gi] ? bus.dat_i[gi*8 +: 8] : w_rdata[gi*8 +: 8];
    end
  endgenerate

  // Out-of-range time values are refused with err and leave the register alone
  assign w_bad       = w_wr & ((w_idx == REG_TIME) | (w_idx == REG_ALARM)) & (w_merged >= DAY_C);
  assign w_ctrl_wr   = w_wr & (w_idx == REG_CTRL);
  assign w_time_wr   = w_wr & (w_idx == REG_TIME) & ~w_bad;
  assign w_alarm_wr  = w_wr & (w_idx == REG_ALARM) & ~w_bad;
  assign w_status_wr = w_wr & (w_idx == REG_STATUS);

  // W1C looks only at written data in lane 0, never at merged old contents
  assign w_clr_fired = w_status_wr & bus.sel_i[0] & bus.dat_i[STATUS_FIRED_BIT];
  assign w_clr_seen  = w_status_wr & bus.sel_i[0] & bus.dat_i[STATUS_TICK_SEEN_BIT];

  // A software time write overrides a coincident tick entirely
  assign w_tick_eff = w_tick & ~w_time_wr;
  assign w_time_inc = (r_time == LAST_C) ? '0 : r_time + DATA_W'(1);
  assign w_fire     = w_tick_eff & r_alarm_en & (w_time_inc == r_alarm);

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .run_i     (r_run),
    .restart_i (w_time_wr),
    .tick_o    (w_tick)
  );

  // Bus FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Bus FSM next state: one response cycle per accepted request
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.cyc_i & bus.stb_i) w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
    endcase
  end

  // Bus FSM outputs: response only while in RESP
  always_comb begin
    bus.ack_o = (r_state == ST_RESP) & ~r_err;
    bus.err_o = (r_state == ST_RESP) &  r_err;
    bus.dat_o = (r_state == ST_RESP) ? r_rdata : '0;
  end

  assign bus.rty_o = 1'b0;
  assign bus.tgd_o = 1'b0;

  // Capture read data and response kind at the accepting edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_req) begin
      r_rdata <= w_rdata;
      r_err   <= w_bad;
    end else begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  // CTRL register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run      <= 1'b0;
      r_alarm_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_run      <= w_merged[CTRL_RUN_BIT];
      r_alarm_en <= w_merged[CTRL_ALARM_EN_BIT];
    end
  end

  // TIME and ALARM registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_time  <= '0;
      r_alarm <= '0;
    end else begin
      if (w_time_wr)       r_time <= w_merged;
      else if (w_tick_eff) r_time <= w_time_inc;
      if (w_alarm_wr)      r_alarm <= w_merged;
    end
  end

  // STATUS flags: hardware set beats a simultaneous software clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fired     <= 1'b0;
      r_tick_seen <= 1'b0;
    end else begin
      r_fired     <= w_fire | (r_fired & ~w_clr_fired);
      r_tick_seen <= w_tick | (r_tick_seen & ~w_clr_seen);
    end
  end

  assign irq_o = r_fired & r_alarm_en;
endmodule

// File: tb/tb_wake_timer.sv
// Randomised self-checking bench for wake_timer with a seconds-level model.
module tb_wake_timer;
  localparam int     CLK_HZ = 4;
  localparam int     DATA_W = 32;
  localparam longint DAY    = 86400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  wishboneSlave #(.DATA_W(DATA_W)) wb ();

  wake_timer #(
    .CLK_HZ (CLK_HZ),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (wb.slave),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit     m_run, m_en, m_fired, m_seen;
  bit     m_set_f, m_set_s;
  longint m_time, m_alarm;
  int     m_phase;

  // Results of the latest transaction
  logic [31:0] g_dat, e_dat;
  logic        g_ack, g_err, g_busy2;
  bit          e_err;

  function automatic void m_reset();
    m_run = 0; m_en = 0; m_fired = 0; m_seen = 0;
    m_time = 0; m_alarm = 0; m_phase = 0;
  endfunction

  // Let n clock edges elapse with no bus write: whole seconds are counted
  // arithmetically and the alarm fires if its value lies among those visited.
  function automatic void m_advance(int n);
    longint total, k, d;
    m_set_f = 0; m_set_s = 0;
    if (n <= 0) return;
    if (!m_run) begin
      m_phase = 0;
      return;
    end
    total   = longint'(m_phase) + n;
    k       = total / CLK_HZ;
    m_phase = int'(total % CLK_HZ);
    if (k > 0) begin
      m_seen = 1; m_set_s = 1;
      if (m_en) begin
        d = (m_alarm - m_time - 1 + DAY) % DAY;
        if (d < k) begin
          m_fired = 1; m_set_f = 1;
        end
      end
      m_time = (m_time + k) % DAY;
    end
  endfunction

  function automatic longint m_read(int idx);
    case (idx)
      0:       return longint'({m_en, m_run});
      1:       return m_time;
      2:       return m_alarm;
      default: return longint'({m_seen, m_fired});
    endcase
  endfunction

  // Effect of the edge that accepts a request; returns whether err is due
  function automatic bit m_bus_edge(bit we, int idx, logic [31:0] data, logic [3:0] sel);
    logic [31:0] old, merged;
    bit tick, bad;
    old = 32'(m_read(idx));
    for (int b = 0; b < 4; b++) merged[b*8 +: 8] = sel[b] ? data[b*8 +: 8] : old[b*8 +: 8];
    bad  = we && (idx == 1 || idx == 2) && (longint'(merged) >= DAY);
    tick = m_run && (m_phase == CLK_HZ - 1);
    if (we && idx == 1 && !bad) begin
      m_time  = longint'(merged);
      m_phase = 0;
      if (tick) m_seen = 1;
    end else begin
      m_advance(1);
      if (we && !bad) begin
        case (idx)
          0: if (sel[0]) begin m_run = data[0]; m_en = data[1]; end
          2: m_alarm = longint'(merged);
          3: if (sel[0]) begin
               if (data[0] && !m_set_f) m_fired = 0;
               if (data[1] && !m_set_s) m_seen  = 0;
             end
          default: ;
        endcase
      end
    end
    return bad;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      m_advance(1);
      #1;
    end
  endtask

  // One complete request/response; called just after a rising edge
  task automatic bus_xfer(input bit we, input int idx, input logic [31:0] data, input logic [3:0] sel);
    wb.adr_i = 32'(idx << 2);
    wb.dat_i = data;
    wb.sel_i = sel;
    wb.we_i  = we;
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    e_dat = 32'(m_read(idx));
    e_err = m_bus_edge(we, idx, data, sel);
    @(posedge clk);
    #1;
    g_dat = wb.dat_o;
    g_ack = wb.ack_o;
    g_err = wb.err_o;
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    @(posedge clk);
    m_advance(1);
    #1;
    g_busy2 = wb.ack_o | wb.err_o;
    $display("xfer t=%0t we=%0d idx=%0d wdat=%h sel=%b ack=%0b err=%0b dat_o=%h", $time, we, idx, data, sel, g_ack, g_err, g_dat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({wb.ack_o, wb.err_o, irq} !== 3'b000 || wb.dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs ack=%b err=%b irq=%b dat_o=%h required all 0", wb.ack_o, wb.err_o, irq, wb.dat_o);
    end
    rst_n = 1'b1;
    m_reset();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b0, i, 32'h0, 4'hf);
      n_checks++;
      if (g_ack !== 1'b1 || g_err !== 1'b0 || g_dat !== 32'h0 || g_busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read idx=%0d ack=%b err=%b dat=%h second=%b required ack=1 err=0 dat=0 second=0", i, g_ack, g_err, g_dat, g_busy2);
      end
    end
  endtask

  task automatic test_wrap();
    bus_xfer(1'b1, 1, 32'd86398, 4'hf);
    n_checks++;
    if (g_ack !== 1'b1 || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_write ack=%b err=%b required ack=1 err=0", g_ack, g_err);
    end
    bus_xfer(1'b1, 0, 32'd1, 4'hf);
    idle(7);
    bus_xfer(1'b0, 1, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== 32'h0 || g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL wrap_time got=%0d required=0 model=%0d", g_dat, e_dat);
    end
    bus_xfer(1'b0, 3, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== 32'h2 || g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL wrap_status got=%h required=2 model=%h", g_dat, e_dat);
    end
  endtask

  task automatic test_alarm();
    bus_xfer(1'b1, 0, 32'd0, 4'hf);
    bus_xfer(1'b1, 2, 32'd10, 4'hf);
    bus_xfer(1'b1, 1, 32'd9, 4'hf);
    bus_xfer(1'b1, 0, 32'd3, 4'hf);
    idle(2);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_early irq=%b required=0", irq);
    end
    idle(1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_irq irq=%b required=1", irq);
    end
    bus_xfer(1'b0, 3, 32'h0, 4'hf);
    n_checks++;
    if (g_dat[0] !== 1'b1 || g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL alarm_fired status=%h required bit0=1 model=%h", g_dat, e_dat);
    end
    bus_xfer(1'b1, 3, 32'h1, 4'hf);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_clear irq=%b required=0", irq);
    end
  endtask

  task automatic test_err_sel();
    bus_xfer(1'b1, 2, 32'd86400, 4'hf);
    n_checks++;
    if (g_err !== 1'b1 || g_ack !== 1'b0 || g_busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_alarm err=%b ack=%b second=%b required err=1 ack=0 second=0", g_err, g_ack, g_busy2);
    end
    bus_xfer(1'b0, 2, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== 32'd10 || g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL err_alarm_kept got=%0d required=10", g_dat);
    end
    bus_xfer(1'b1, 0, 32'd0, 4'hf);
    bus_xfer(1'b1, 1, 32'd86399, 4'hf);
    n_checks++;
    if (g_ack !== 1'b1 || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL last_second_write ack=%b err=%b required ack=1 err=0", g_ack, g_err);
    end
    bus_xfer(1'b1, 1, 32'h200, 4'hf);
    bus_xfer(1'b1, 1, 32'h105, 4'b0001);
    bus_xfer(1'b0, 1, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== 32'h205) begin
      n_fail++;
      $display("FAIL byte_sel got=%h required=205", g_dat);
    end
  endtask

  task automatic test_collision();
    bus_xfer(1'b1, 0, 32'd0, 4'hf);
    bus_xfer(1'b1, 1, 32'd100, 4'hf);
    bus_xfer(1'b1, 2, 32'd101, 4'hf);
    bus_xfer(1'b1, 0, 32'd3, 4'hf);
    for (int i = 0; i < CLK_HZ && m_phase != CLK_HZ - 1; i++) idle(1);
    bus_xfer(1'b1, 3, 32'h1, 4'h1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_vs_fire irq=%b required=1", irq);
    end
    bus_xfer(1'b0, 3, 32'h0, 4'hf);
    n_checks++;
    if (g_dat[0] !== 1'b1 || g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL w1c_vs_fire_status got=%h required bit0=1 model=%h", g_dat, e_dat);
    end
    for (int i = 0; i < CLK_HZ && m_phase != CLK_HZ - 1; i++) idle(1);
    bus_xfer(1'b1, 1, 32'd50, 4'hf);
    n_checks++;
    if (g_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_write ack=%b required=1", g_ack);
    end
    bus_xfer(1'b0, 1, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== 32'd50) begin
      n_fail++;
      $display("FAIL tick_write_wins got=%0d required=50", g_dat);
    end
    bus_xfer(1'b0, 1, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL tick_restart_a got=%0d required=%0d", g_dat, e_dat);
    end
    bus_xfer(1'b0, 1, 32'h0, 4'hf);
    n_checks++;
    if (g_dat !== 32'd51 || g_dat !== e_dat) begin
      n_fail++;
      $display("FAIL tick_restart_b got=%0d required=51", g_dat);
    end
  endtask

  task automatic test_random();
    int          idx, pick;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] data;
    for (int t = 0; t < 120; t++) begin
      idle($urandom_range(0, 3));
      idx  = $urandom_range(0, 3);
      we   = 1'($urandom_range(0, 1));
      sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      pick = $urandom_range(0, 3);
      case (idx)
        0: data = $urandom | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
        1: data = (pick == 0) ? 32'($urandom_range(86390, 86410)) :
                  (pick == 1) ? $urandom : 32'($urandom_range(0, 86399));
        2: data = (pick == 3) ? 32'($urandom_range(86398, 86402)) : 32'((m_time + $urandom_range(1, 3)) % DAY);
        default: data = $urandom;
      endcase
      bus_xfer(we, idx, data, sel);
      n_checks++;
      if (g_ack !== !e_err || g_err !== e_err) begin
        n_fail++;
        $display("FAIL rand_resp t=%0d ack=%b err=%b required ack=%b err=%b", t, g_ack, g_err, !e_err, e_err);
      end
      n_checks++;
      if (g_dat !== e_dat) begin
        n_fail++;
        $display("FAIL rand_data t=%0d idx=%0d got=%h required=%h", t, idx, g_dat, e_dat);
      end
      n_checks++;
      if (g_busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_single_cycle t=%0d second_cycle_resp=%b required=0", t, g_busy2);
      end
      n_checks++;
      if (irq !== (m_fired & m_en)) begin
        n_fail++;
        $display("FAIL rand_irq t=%0d irq=%b required=%b", t, irq, m_fired & m_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus_xfer(1'b1, 0, 32'd3, 4'hf);
    wb.adr_i = 32'h0;
    wb.we_i  = 1'b0;
    wb.sel_i = 4'hf;
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb.ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre ack=%b required=1", wb.ack_o);
    end
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wb.ack_o, wb.err_o, irq} !== 3'b000 || wb.dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_abort ack=%b err=%b irq=%b dat_o=%h required all 0", wb.ack_o, wb.err_o, irq, wb.dat_o);
    end
    m_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_xfer(1'b0, 0, 32'h0, 4'hf);
    n_checks++;
    if (g_ack !== 1'b1 || g_err !== 1'b0 || g_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_after ack=%b err=%b dat=%h required ack=1 err=0 dat=0", g_ack, g_err, g_dat);
    end
  endtask

  initial begin
    wb.adr_i = '0;
    wb.dat_i = '0;
    wb.sel_i = '0;
    wb.we_i  = 1'b0;
    wb.stb_i = 1'b0;
    wb.cyc_i = 1'b0;
    m_reset();
    test_reset();
    test_wrap();
    test_alarm();
    test_err_sel();
    test_collision();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1);
  end
endmodule
